// File: rtl/magnitude_pkg.sv
// Shared types and constants for the magnitude window statistics block.
package magnitude_pkg;

  localparam int MAG_W = 8;

  typedef enum logic [1:0] {NORMAL, PEND_ON, ALARM, PEND_OFF} alarm_state_t;
  typedef enum logic {IDLE, ACCUM} win_state_t;

  function automatic logic [MAG_W-1:0] max_mag(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mag_alarm_debounce.sv
// Over-threshold alarm with hysteresis counted in whole windows.
// Advances only on a window-close strobe; clear returns it to NORMAL.
module mag_alarm_debounce
  import magnitude_pkg::*;
#(
  parameter int HOLD_WIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             close,
  input  logic [MAG_W-1:0] avg,
  input  logic [MAG_W-1:0] thresh,
  input  logic             clear,
  output logic             alarm,
  output alarm_state_t     state
);

  localparam logic [3:0] HOLD_LIM = HOLD_WIN[3:0];

  alarm_state_t state_next;
  logic [3:0]   hold, hold_next, hold_inc;
  logic         over;

  assign over     = (avg > thresh);
  assign hold_inc = hold + 4'd1;
  assign alarm    = (state == ALARM) || (state == PEND_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      hold  <= 4'd0;
    end else if (clear) begin
      state <= NORMAL;
      hold  <= 4'd0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  // A non-qualifying window while pending abandons the streak entirely.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    if (close) begin
      case (state)
        NORMAL: if (over) begin
          if (HOLD_LIM == 4'd1) state_next = ALARM;
          else begin
            state_next = PEND_ON;
            hold_next  = 4'd1;
          end
        end
        PEND_ON: if (over) begin
          if (hold_inc == HOLD_LIM) begin
            state_next = ALARM;
            hold_next  = 4'd0;
          end else hold_next = hold_inc;
        end else begin
          state_next = NORMAL;
          hold_next  = 4'd0;
        end
        ALARM: if (!over) begin
          if (HOLD_LIM == 4'd1) state_next = NORMAL;
          else begin
            state_next = PEND_OFF;
            hold_next  = 4'd1;
          end
        end
        PEND_OFF: if (!over) begin
          if (hold_inc == HOLD_LIM) begin
            state_next = NORMAL;
            hold_next  = 4'd0;
          end else hold_next = hold_inc;
        end else begin
          state_next = ALARM;
          hold_next  = 4'd0;
        end
        default: begin
          state_next = NORMAL;
          hold_next  = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/magnitude_window_stats.sv
// Windowed average/peak of magnitude samples with a debounced threshold alarm.
// Handshake: a sample is taken on every edge where ena && mag_valid && !clear; no backpressure.
module magnitude_window_stats
  import magnitude_pkg::*;
#(
  parameter int LOG2_WIN = 3,
  parameter int HOLD_WIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             mag_valid,
  input  logic             clear,
  input  logic [MAG_W-1:0] thresh,
  output logic [MAG_W-1:0] avg_out,
  output logic [MAG_W-1:0] peak_out,
  output logic             win_done,
  output logic             alarm,
  output logic             busy
);

  localparam int ACC_W = MAG_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST = '1;

  logic [ACC_W-1:0]    acc, acc_next, sum;
  logic [LOG2_WIN-1:0] count, count_next;
  logic [MAG_W-1:0]    peak, peak_next, peak_new, avg_new;
  win_state_t          win_state, win_state_next;
  alarm_state_t        alarm_state;
  logic                accept, close;

  assign accept   = ena && mag_valid && !clear;
  assign close    = accept && (count == LAST);
  // The accumulator is sized so a full window of 255s cannot wrap.
  assign sum      = acc + ACC_W'(mag_in);
  assign avg_new  = sum[ACC_W-1:LOG2_WIN];
  assign peak_new = (win_state == IDLE) ? mag_in : max_mag(peak, mag_in);

  always_comb begin
    acc_next       = acc;
    count_next     = count;
    peak_next      = peak;
    win_state_next = win_state;
    if (accept) begin
      if (close) begin
        acc_next       = '0;
        count_next     = '0;
        peak_next      = '0;
        win_state_next = IDLE;
      end else begin
        acc_next       = sum;
        count_next     = count + LOG2_WIN'(1);
        peak_next      = peak_new;
        win_state_next = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      peak      <= '0;
      win_state <= IDLE;
      avg_out   <= '0;
      peak_out  <= '0;
      win_done  <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      count     <= '0;
      peak      <= '0;
      win_state <= IDLE;
      avg_out   <= '0;
      peak_out  <= '0;
      win_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      acc       <= acc_next;
      count     <= count_next;
      peak      <= peak_next;
      win_state <= win_state_next;
      win_done  <= close;
      busy      <= (count_next != '0);
      if (close) begin
        avg_out  <= avg_new;
        peak_out <= peak_new;
      end
    end
  end

  mag_alarm_debounce #(.HOLD_WIN(HOLD_WIN)) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .close  (close),
    .avg    (avg_new),
    .thresh (thresh),
    .clear  (clear),
    .alarm  (alarm),
    .state  (alarm_state)
  );

endmodule

// File: tb/tb_magnitude_window_stats.sv
// Directed and randomized bench for magnitude_window_stats against a queue-based window model.
module tb_magnitude_window_stats;

  localparam int LOG2_WIN = 3;
  localparam int HOLD_WIN = 4;
  localparam int WIN      = 1 << LOG2_WIN;

  logic       clk, rst_n, ena, mag_valid, clear;
  logic [7:0] mag_in, thresh, avg_out, peak_out;
  logic       win_done, alarm, busy;

  magnitude_window_stats #(.LOG2_WIN(LOG2_WIN), .HOLD_WIN(HOLD_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mag_in(mag_in), .mag_valid(mag_valid),
    .clear(clear), .thresh(thresh), .avg_out(avg_out), .peak_out(peak_out),
    .win_done(win_done), .alarm(alarm), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: samples of the open window, last results, alarm streak.
  int          win_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  m_avg, m_peak;
  logic        m_done, m_alarm;
  int          streak;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    exp_q.delete();
    m_avg = 0; m_peak = 0; m_done = 0; m_alarm = 0; streak = 0;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [7:0] m,
                            input logic c, input logic [7:0] t);
    if (c) model_reset();
    else begin
      m_done = 0;
      if (e && v) begin
        win_q.push_back(int'(m));
        if (win_q.size() == WIN) begin
          int  s, mx;
          bit  qual;
          s = 0; mx = 0;
          foreach (win_q[i]) begin
            s += win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
          end
          win_q.delete();
          m_avg  = 8'(s / WIN);
          m_peak = 8'(mx);
          m_done = 1;
          exp_q.push_back({m_avg, m_peak});
          qual = m_alarm ? (m_avg <= t) : (m_avg > t);
          streak = qual ? streak + 1 : 0;
          if (streak == HOLD_WIN) begin
            m_alarm = !m_alarm;
            streak  = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("win_done", 16'(win_done), 16'(m_done));
    check("avg_out",  16'(avg_out),  16'(m_avg));
    check("peak_out", 16'(peak_out), 16'(m_peak));
    check("alarm",    16'(alarm),    16'(m_alarm));
    check("busy",     16'(busy),     16'(win_q.size() != 0));
    if (win_done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_window", 16'd1, 16'd0);
      else check("window_result", {avg_out, peak_out}, exp_q.pop_front());
    end
  endtask

  // Driver: inputs change 1 time unit after a rising edge; outputs checked at the same offset.
  task automatic step(input logic e, input logic v, input logic [7:0] m, input logic c);
    ena = e; mag_valid = v; mag_in = m; clear = c;
    @(posedge clk);
    model_edge(e, v, m, c, thresh);
    #1 check_all();
  endtask

  task automatic feed_window(input int n);
    for (int k = 0; k < WIN / 2; k++) begin
      int d;
      d = $urandom_range(0, 9);
      step(1, 1, 8'(n + d), 0);
      step(1, 1, 8'(n - d), 0);
    end
  endtask

  int avgs[11]      = '{50, 50, 30, 50, 50, 50, 50, 40, 40, 40, 40};
  bit alarm_exp[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    ena = 0; mag_valid = 0; mag_in = 0; clear = 0; thresh = 8'd40; rst_n = 0;
    model_reset();
    #12;
    check("reset_avg",   16'(avg_out),  16'd0);
    check("reset_peak",  16'(peak_out), 16'd0);
    check("reset_done",  16'(win_done), 16'd0);
    check("reset_alarm", 16'(alarm),    16'd0);
    check("reset_busy",  16'(busy),     16'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Ramp window 10..80
    for (int i = 1; i <= WIN; i++) step(1, 1, 8'(i * 10), 0);
    check("ramp_done", 16'(win_done), 16'd1);
    check("ramp_avg",  16'(avg_out),  16'd45);
    check("ramp_peak", 16'(peak_out), 16'd80);
    step(1, 0, 0, 0);
    check("ramp_busy_after", 16'(busy), 16'd0);

    // Full-scale window, then a near-empty one
    for (int i = 0; i < WIN; i++) step(1, 1, 8'd255, 0);
    check("sat_avg",  16'(avg_out),  16'd255);
    check("sat_peak", 16'(peak_out), 16'd255);
    for (int i = 0; i < WIN - 1; i++) step(1, 1, 8'd0, 0);
    step(1, 1, 8'd7, 0);
    check("low_avg",  16'(avg_out),  16'd0);
    check("low_peak", 16'(peak_out), 16'd7);

    // Alarm hysteresis from a clean state
    step(0, 0, 0, 1);
    thresh = 8'd40;
    foreach (avgs[w]) begin
      feed_window(avgs[w]);
      check($sformatf("alarm_win%0d", w + 1), 16'(alarm), 16'(alarm_exp[w]));
    end

    // Sparse valid with an ena-low stretch mid-window
    begin
      int acc_n;
      bit froze;
      acc_n = 0; froze = 0;
      while (acc_n < WIN) begin
        bit v;
        if (acc_n == 3 && !froze) begin
          froze = 1;
          for (int k = 0; k < 5; k++) step(0, 1, 8'($urandom_range(0, 255)), 0);
        end
        v = 1'($urandom_range(0, 1));
        step(1, v, 8'($urandom_range(0, 255)), 0);
        if (v) acc_n++;
      end
      check("gap_done", 16'(win_done), 16'd1);
    end

    // Clear with a simultaneous sample, then a clean window
    for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom_range(0, 255)), 0);
    step(1, 1, 8'd99, 1);
    check("clear_avg",  16'(avg_out), 16'd0);
    check("clear_busy", 16'(busy),    16'd0);
    for (int i = 0; i < WIN; i++) step(1, 1, 8'($urandom_range(0, 255)), 0);
    check("post_clear_done", 16'(win_done), 16'd1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom_range(0, 255)), 0);
    ena = 0; mag_valid = 0;
    #2 rst_n = 0;
    #1;
    check("async_rst_avg",  16'(avg_out),  16'd0);
    check("async_rst_busy", 16'(busy),     16'd0);
    check("async_rst_done", 16'(win_done), 16'd0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_all();

    // Back-to-back windows
    for (int i = 0; i < 2 * WIN; i++) step(1, 1, 8'($urandom_range(0, 255)), 0);
    check("b2b_done", 16'(win_done), 16'd1);

    // Random soak
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) thresh = 8'($urandom_range(60, 200));
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/magnitude_window_stats.md
Name: magnitude_window_stats

Overview:
Downstream consumer of the 8-bit magnitude stage that produces sqrt(x^2+y^2).
- Collects magnitude samples into fixed windows of 2^LOG2_WIN samples.
- Reports per-window truncated average and peak.
- Drives a debounced over-threshold alarm with hysteresis in window counts.
- Output feeds status pins / host readout.

Parameters:
LOG2_WIN, 3, log2 of window length (window = 8 samples); legal 1..6
HOLD_WIN, 4, consecutive qualifying windows required to set or clear alarm; legal 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state, samples ignored
mag_in  in  8  magnitude sample
mag_valid  in  1  mag_in valid this cycle (single-cycle qualifier, no backpressure)
clear  in  1  synchronous clear of window and alarm state
thresh  in  8  alarm threshold, sampled at each window close
avg_out  out  8  average of last completed window
peak_out  out  8  max sample of last completed window
win_done  out  1  one-cycle pulse: avg_out/peak_out just updated
alarm  out  1  debounced over-threshold flag
busy  out  1  high while current window holds ≥1 sample

Behaviour:
- Reset (async, rst_n=0): acc, sample count, running peak, hold counter = 0; alarm FSM = NORMAL. avg_out, peak_out, win_done, alarm, busy = 0.
- Accepted sample: ena=1 && mag_valid=1 && clear=0.
- Accumulator: 8+LOG2_WIN bits; no overflow possible (255*64 fits 14 bits).
- Sample count: LOG2_WIN bits; running peak: 8 bits.
- Window FSM:
  - IDLE: count=0. Accepted sample -> acc=mag, peak=mag, count=1 -> ACCUM. If LOG2_WIN window is 1-sample-closing (count wraps), close immediately instead.
  - ACCUM: each accepted sample adds to acc, peak=max(peak, mag), count++.
- Window close: accepted sample while count = 2^LOG2_WIN-1. On that same edge:
  - avg_out = (acc+mag_in) >> LOG2_WIN (truncating)
  - peak_out = max(peak, mag_in)
  - win_done = 1 for exactly one cycle
  - acc, count, peak = 0 -> IDLE
- Back-to-back: an accepted sample in the cycle after close starts the next window; no dead cycle, no sample dropped.
- busy = (count != 0), registered.
- Alarm FSM: evaluated only on window close, using the new avg and thresh at that edge.
  - States: NORMAL, PEND_ON, ALARM, PEND_OFF.
  - Qualify-on: avg > thresh (strict). Qualify-off: avg <= thresh.
  - NORMAL: qualify-on -> hold=1 and PEND_ON; if HOLD_WIN=1 go directly to ALARM.
  - PEND_ON: qualify-on -> hold++; at hold==HOLD_WIN -> ALARM, hold=0. Non-qualifying window -> NORMAL, hold=0.
  - ALARM / PEND_OFF: mirror image with qualify-off, returning to NORMAL.
  - alarm=1 in ALARM and PEND_OFF; alarm=0 otherwise. alarm changes on the same edge as the win_done rising.
- ena=0: all registers hold, win_done forced 0 next cycle. A pulse already high drops after one cycle regardless.
- clear=1 (ena ignored):
  - next edge: acc/count/peak/hold = 0; FSMs to IDLE/NORMAL; avg_out, peak_out, alarm, win_done, busy = 0
  - clear overrides a simultaneous mag_valid; that sample is dropped
- thresh change mid-window: no effect until next close.
- Reset mid-window: partial window discarded, no win_done.

Decomposition:
- Shared package magnitude_pkg:
  - MAG_W=8
  - alarm state enum (NORMAL, PEND_ON, ALARM, PEND_OFF)
  - window state enum (IDLE, ACCUM)
- One natural sub-module: mag_alarm_debounce.
  - Alarm FSM plus hold counter.
  - Inputs: close strobe, avg, thresh, clear. Output: alarm.
- Window accumulator stays in the top.

Test Plan:
- Window stats: LOG2_WIN=3, valid samples 10,20,...,80 contiguous -> one win_done pulse after 8th edge, avg_out=45, peak_out=80, busy low afterwards.
- Saturation width: eight samples of 255 -> avg_out=255, peak_out=255, no wrap. Then samples 0,0,0,0,0,0,0,7 -> avg_out=0, peak_out=7.
- Alarm debounce: HOLD_WIN=4, thresh=40.
  - Windows avg 50,50,30,50,50,50,50 -> alarm stays 0 through window 6, rises on 7th win_done.
  - Then four windows avg 40 -> alarm falls on 4th (40 not > 40).
- Gaps/ena: mag_valid sparse with idle cycles, and ena low 5 cycles mid-window with mag_valid=1 -> frozen samples ignored; window closes only after 8 accepted samples, correct avg.
- Clear and reset: clear asserted with mag_valid after 5 samples -> all outputs 0 next cycle, sample dropped, following 8 samples form a clean window. rst_n pulsed low mid-window asynchronously -> outputs 0 immediately, no spurious win_done.
- Back-to-back windows: 16 contiguous valid samples -> win_done pulses exactly at sample 8 and sample 16, second window stats independent of first.
